// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one memory line port between the I-cache
// and D-cache; one transaction at a time, registered one-cycle response.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((LINE_W / 8) - 1);

  typedef enum logic [2:0] {
    IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE
  } state_t;

  state_t            state, state_nx;
  logic              last_d;
  logic              op_wr;
  logic [LINE_W-1:0] line_buf;
  logic              i_req, d_req;
  logic              grant_i, grant_d;
  logic [ADDR_W-1:0] i_line, d_line;

  assign i_req  = i_read;
  assign d_req  = d_read | d_write;
  assign i_line = i_address & ~OFF_MASK;
  assign d_line = d_address & ~OFF_MASK;

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    unique case (state)
      IDLE: begin
        // tie goes to the side that did not win last
        if (i_req && d_req) begin
          grant_d = ~last_d;
          grant_i = last_d;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i)      state_nx = I_BUSY;
        else if (grant_d) state_nx = D_BUSY;
      end
      I_BUSY: if (pmem_resp) state_nx = I_DONE;
      D_BUSY: if (pmem_resp) state_nx = D_DONE;
      I_DONE: state_nx = IDLE;
      D_DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_d       <= 1'b0;
      op_wr        <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      line_buf     <= '0;
    end else begin
      state <= state_nx;
      if (grant_i) begin
        pmem_address <= i_line;
        op_wr        <= 1'b0;
        last_d       <= 1'b0;
      end
      if (grant_d) begin
        pmem_address <= d_line;
        op_wr        <= d_write;
        last_d       <= 1'b1;
        if (d_write) pmem_wdata <= d_wdata;
      end
      if ((state == I_BUSY || state == D_BUSY) &&
          pmem_resp && !op_wr)
        line_buf <= pmem_rdata;
    end
  end

  assign pmem_read  = (state == I_BUSY) ||
                      (state == D_BUSY && !op_wr);
  assign pmem_write = (state == D_BUSY) && op_wr;
  assign i_resp     = (state == I_DONE);
  assign d_resp     = (state == D_DONE);
  assign i_rdata    = line_buf;
  assign d_rdata    = line_buf;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter against a transaction-level
// round-robin model with a behavioural memory responder.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read, d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int total = 0;
  int bad   = 0;

  // model state: who won last, and the last line read from memory
  bit            m_last_d;
  logic [LW-1:0] m_buf;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write),
    .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [LW-1:0] got,
                     input logic [LW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return (a / (LW / 8)) * (LW / 8);
  endfunction

  // Runs one memory transaction for the side is_d; dly is the number
  // of falling edges from call until the memory op must be visible.
  task automatic serve(input bit is_d, input logic [AW-1:0] addr,
                       input bit wr, input logic [LW-1:0] wd,
                       input int lat, input int dly,
                       input bit raise_other,
                       input logic [LW-1:0] line);
    int n = 0;
    logic [AW-1:0] ea;
    ea = align(addr);
    do begin
      @(negedge clk);
      n++;
      if (!(pmem_read | pmem_write))
        chk("quiet_resp", {i_resp, d_resp}, 0);
    end while (!(pmem_read | pmem_write) && n < 16);
    chk("grant_delay", n, dly);
    chk("grant_side_wr", pmem_write, wr);
    chk("grant_side_rd", pmem_read, !wr);
    chk("pmem_addr", pmem_address, ea);
    if (wr) chk("pmem_wdata", pmem_wdata, wd);
    if (is_d) d_address = $urandom;
    else      i_address = $urandom;
    if (raise_other) begin
      if (is_d) i_read = 1'b1;
      else      d_read = 1'b1;
    end
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk("hold_op", {pmem_read, pmem_write}, {!wr, wr});
      chk("hold_addr", pmem_address, ea);
      chk("hold_resp", {i_resp, d_resp}, 0);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = line;
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = rnd_line();
    if (!wr) m_buf = line;
    chk("resp_i", i_resp, !is_d);
    chk("resp_d", d_resp, is_d);
    chk("done_op", {pmem_read, pmem_write}, 0);
    chk("rdata", is_d ? d_rdata : i_rdata, m_buf);
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  // mode 0: I only, 1: D only, 2: both at once, 3: one then other late
  task automatic round(input int mode, input int dop,
                       input logic [AW-1:0] ia,
                       input logic [AW-1:0] da,
                       input logic [LW-1:0] wd,
                       input int l1, input int l2);
    bit first_d, two, dwr;
    dwr = (dop != 0);
    two = (mode >= 2);
    if (mode == 0)      first_d = 1'b0;
    else if (mode == 1) first_d = 1'b1;
    else if (mode == 2) first_d = !m_last_d;
    else                first_d = $urandom_range(0, 1) != 0;
    i_address = ia;
    d_address = da;
    d_wdata   = wd;
    if (mode == 0 || mode == 2 || (mode == 3 && !first_d))
      i_read = 1'b1;
    if (mode == 1 || mode == 2 || (mode == 3 && first_d)) begin
      d_read  = (dop == 0 || dop == 2);
      d_write = (dop != 0);
    end
    if (mode == 3 && first_d) begin
      d_read  = (dop == 0 || dop == 2);
      d_write = dwr;
    end
    serve(first_d, first_d ? da : ia, first_d ? dwr : 1'b0, wd,
          l1, 1, mode == 3, rnd_line());
    m_last_d = first_d;
    if (two) begin
      if (mode == 3 && !first_d) begin
        d_address = da;
        d_read    = (dop == 0 || dop == 2);
        d_write   = dwr;
      end
      if (mode == 3 && first_d) i_address = ia;
      serve(!first_d, first_d ? ia : da, first_d ? 1'b0 : dwr, wd,
            l2, 2, 1'b0, rnd_line());
      m_last_d = !first_d;
    end
    @(negedge clk);
    chk("idle_resp", {i_resp, d_resp}, 0);
    chk("idle_op", {pmem_read, pmem_write}, 0);
  endtask

  logic [LW-1:0] a5;
  logic [LW-1:0] pat;

  initial begin
    rst_n = 1'b0;
    i_read = 0; i_address = 0;
    d_read = 0; d_write = 0; d_address = 0; d_wdata = 0;
    pmem_rdata = 0; pmem_resp = 0;
    m_last_d = 1'b0;
    m_buf = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_op", {pmem_read, pmem_write}, 0);
    chk("rst_resp", {i_resp, d_resp}, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_rdata", i_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // first tie after reset goes to D, then I
    round(2, 0, 32'h0000_1000, 32'h0000_2040, '0, 2, 2);
    // I read of 0x64 with 3-cycle memory
    for (int k = 0; k < LW / 8; k++) a5[k*8 +: 8] = 8'hA5;
    i_address = 32'h0000_0064;
    i_read = 1'b1;
    serve(1'b0, 32'h0000_0064, 1'b0, '0, 3, 1, 1'b0, a5);
    m_last_d = 1'b0;
    chk("a5_line", i_rdata, a5);
    @(negedge clk);
    chk("a5_idle", {i_resp, d_resp}, 0);
    // D write of 0x8000_003F
    pat = rnd_line();
    round(1, 1, 32'h0, 32'h8000_003F, pat, 2, 1);
    chk("wr_addr_align", align(32'h8000_003F), 32'h8000_0020);
    // tie after I won goes to D; tie after D won goes to I
    round(0, 0, 32'h44, 32'h0, '0, 1, 1);
    round(2, 0, 32'h100, 32'h200, '0, 1, 1);
    round(2, 0, 32'h300, 32'h400, '0, 1, 1);
    // d_read and d_write both set acts as a write
    round(1, 2, 32'h0, 32'h0000_0ABC, rnd_line(), 2, 1);
    // late request during busy waits for IDLE
    round(3, 0, 32'h5000, 32'h6000, '0, 4, 2);

    for (int r = 0; r < 300; r++)
      round($urandom_range(0, 3), $urandom_range(0, 2),
            $urandom, $urandom, rnd_line(),
            $urandom_range(1, 6), $urandom_range(1, 6));

    // async reset in the middle of a D transaction
    round(0, 0, 32'h40, 32'h0, '0, 1, 1);
    d_address = 32'h0000_7700;
    d_read = 1'b1;
    @(negedge clk);
    chk("mid_op", pmem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_op", {pmem_read, pmem_write}, 0);
    chk("async_resp", {i_resp, d_resp}, 0);
    chk("async_addr", pmem_address, 0);
    d_read = 1'b0;
    m_last_d = 1'b0;
    m_buf = '0;
    @(negedge clk);
    rst_n = 1'b1;
    pmem_resp = 1'b1;
    pmem_rdata = rnd_line();
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("late_resp", {i_resp, d_resp}, 0);
    chk("late_op", {pmem_read, pmem_write}, 0);
    @(negedge clk);
    chk("late_resp2", {i_resp, d_resp}, 0);
    chk("late_buf", d_rdata, 0);
    round(2, 0, 32'h900, 32'hA00, '0, 2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
